// File: rtl/branch_pkg.sv
// Shared constants for the RV32I branch resolver: default widths and the
// funct3 encodings of the conditional branch instructions.
package branch_pkg;

  localparam int XLEN_DEFAULT    = 32;
  localparam int PC_STEP_DEFAULT = 4;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch-condition evaluator: turns the registered
// difference and operand signs into taken/illegal for one funct3.
module branch_cond_eval
  import branch_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [XLEN:0] diff,
  input  logic          sign_a,
  input  logic          sign_b,
  input  logic [2:0]    funct3,
  output logic          taken,
  output logic          illegal
);

  localparam int LEAVES = 1 << $clog2(XLEN);

  // Heap-ordered pairwise OR tree keeps the zero detect at log2(XLEN) levels.
  function automatic logic any_set(input logic [LEAVES-1:0] v);
    logic [2*LEAVES-2:0] t;
    t = '0;
    t[LEAVES-1 +: LEAVES] = v;
    for (int i = LEAVES - 2; i >= 0; i--) begin
      t[i] = t[2*i+1] | t[2*i+2];
    end
    return t[0];
  endfunction

  logic eq;
  logic lt;
  logic ltu;

  assign eq  = ~any_set(LEAVES'(diff[XLEN-1:0]));
  assign lt  = (sign_a != sign_b) ? sign_a : diff[XLEN-1];
  assign ltu = diff[XLEN];

  always_comb begin
    taken   = 1'b0;
    illegal = 1'b0;
    case (funct3)
      F3_BEQ:  taken = eq;
      F3_BNE:  taken = ~eq;
      F3_BLT:  taken = lt;
      F3_BGE:  taken = ~lt;
      F3_BLTU: taken = ltu;
      F3_BGEU: taken = ~ltu;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Two-stage pipelined branch resolver with valid/ready on both sides.
// Define BRANCH_RESOLVE_STATS_EN to add branch/taken/mispredict counters.
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int XLEN    = XLEN_DEFAULT,
  parameter int PC_STEP = PC_STEP_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  input  logic            pred_taken,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            taken,
  output logic [XLEN-1:0] next_pc,
  output logic            mispredict,
`ifdef BRANCH_RESOLVE_STATS_EN
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_taken,
  output logic [31:0]     stat_mispredict,
`endif
  output logic            illegal
);

  logic            s1_valid;
  logic [XLEN:0]   s1_diff;
  logic            s1_sign_a;
  logic            s1_sign_b;
  logic [XLEN-1:0] s1_target;
  logic [XLEN-1:0] s1_seq;
  logic [2:0]      s1_funct3;
  logic            s1_pred;
  logic            s2_valid;
  logic            s1_adv;
  logic            eval_taken;
  logic            eval_illegal;

  assign s1_adv    = ~s2_valid | out_ready;
  assign in_ready  = ~s1_valid | s1_adv;
  assign out_valid = s2_valid;

  // Flush only kills the valid bits; stale data behind them is harmless.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else if (flush) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      if (in_ready) s1_valid <= in_valid;
      if (s1_adv)   s2_valid <= s1_valid;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_diff   <= '0;
      s1_sign_a <= 1'b0;
      s1_sign_b <= 1'b0;
      s1_target <= '0;
      s1_seq    <= '0;
      s1_funct3 <= '0;
      s1_pred   <= 1'b0;
    end else if (in_valid && in_ready) begin
      s1_diff   <= {1'b0, rs1} - {1'b0, rs2};
      s1_sign_a <= rs1[XLEN-1];
      s1_sign_b <= rs2[XLEN-1];
      s1_target <= pc + imm;
      s1_seq    <= pc + XLEN'(PC_STEP);
      s1_funct3 <= funct3;
      s1_pred   <= pred_taken;
    end
  end

  branch_cond_eval #(.XLEN(XLEN)) u_cond (
    .diff    (s1_diff),
    .sign_a  (s1_sign_a),
    .sign_b  (s1_sign_b),
    .funct3  (s1_funct3),
    .taken   (eval_taken),
    .illegal (eval_illegal)
  );

  // Illegal entries never report taken, so mispredict collapses to the prediction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      taken      <= 1'b0;
      next_pc    <= '0;
      mispredict <= 1'b0;
      illegal    <= 1'b0;
    end else if (s1_valid && s1_adv) begin
      taken      <= eval_taken;
      next_pc    <= eval_taken ? s1_target : s1_seq;
      mispredict <= eval_taken ^ s1_pred;
      illegal    <= eval_illegal;
    end
  end

`ifdef BRANCH_RESOLVE_STATS_EN
  logic deliver_legal;
  assign deliver_legal = out_valid & out_ready & ~illegal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_branches   <= '0;
      stat_taken      <= '0;
      stat_mispredict <= '0;
    end else if (deliver_legal) begin
      stat_branches <= stat_branches + 32'd1;
      if (taken)      stat_taken      <= stat_taken + 32'd1;
      if (mispredict) stat_mispredict <= stat_mispredict + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed self-checking bench for branch_resolve_unit; also checks the
// counters when built with BRANCH_RESOLVE_STATS_EN.
module tb_branch_resolve_unit;
  import branch_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic [2:0]  funct3;
  logic [31:0] pc;
  logic [31:0] imm;
  logic        pred_taken;
  logic        out_valid;
  logic        out_ready;
  logic        taken;
  logic [31:0] next_pc;
  logic        mispredict;
  logic        illegal;
`ifdef BRANCH_RESOLVE_STATS_EN
  logic [31:0] stat_branches;
  logic [31:0] stat_taken;
  logic [31:0] stat_mispredict;
`endif

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  branch_resolve_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .rs1        (rs1),
    .rs2        (rs2),
    .funct3     (funct3),
    .pc         (pc),
    .imm        (imm),
    .pred_taken (pred_taken),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .taken      (taken),
    .next_pc    (next_pc),
    .mispredict (mispredict),
`ifdef BRANCH_RESOLVE_STATS_EN
    .stat_branches   (stat_branches),
    .stat_taken      (stat_taken),
    .stat_mispredict (stat_mispredict),
`endif
    .illegal    (illegal)
  );

  task automatic check_bit(input string tag, input logic observed, input logic expected);
    checks++;
    assert (observed === expected) else begin
      fails++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
    end
  endtask

  task automatic check_word(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      fails++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic check_output(input string tag, input logic exp_taken, input logic [31:0] exp_pc,
                              input logic exp_mis, input logic exp_ill);
    check_bit({tag, ".out_valid"}, out_valid, 1'b1);
    check_bit({tag, ".taken"}, taken, exp_taken);
    check_word({tag, ".next_pc"}, next_pc, exp_pc);
    check_bit({tag, ".mispredict"}, mispredict, exp_mis);
    check_bit({tag, ".illegal"}, illegal, exp_ill);
  endtask

  task automatic apply_stimulus(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f3,
                                input logic [31:0] p, input logic [31:0] i, input logic pr);
    in_valid   = 1'b1;
    rs1        = a;
    rs2        = b;
    funct3     = f3;
    pc         = p;
    imm        = i;
    pred_taken = pr;
  endtask

  task automatic go_idle();
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    rs1 = '0; rs2 = '0; funct3 = '0; pc = '0; imm = '0; pred_taken = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check_bit("reset.out_valid", out_valid, 1'b0);
    check_bit("reset.taken", taken, 1'b0);
    check_word("reset.next_pc", next_pc, 32'h0);
    check_bit("reset.mispredict", mispredict, 1'b0);
    check_bit("reset.illegal", illegal, 1'b0);
    check_bit("reset.in_ready", in_ready, 1'b1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] BEQ taken with 2-cycle latency");
    apply_stimulus(32'd5, 32'd5, F3_BEQ, 32'h100, 32'h20, 1'b0);
    #1 check_bit("beq.in_ready", in_ready, 1'b1);
    @(negedge clk);
    go_idle();
    check_bit("beq.latency1", out_valid, 1'b0);
    @(negedge clk);
    check_output("beq", 1'b1, 32'h120, 1'b1, 1'b0);
    @(negedge clk);
    check_bit("beq.drained", out_valid, 1'b0);

    $display("[TB] signed vs unsigned compare, back to back");
    apply_stimulus(32'hFFFF_FFFF, 32'd1, F3_BLT, 32'h200, 32'h40, 1'b0);
    @(negedge clk);
    apply_stimulus(32'hFFFF_FFFF, 32'd1, F3_BLTU, 32'h200, 32'h40, 1'b1);
    @(negedge clk);
    go_idle();
    check_output("blt", 1'b1, 32'h240, 1'b1, 1'b0);
    @(negedge clk);
    check_output("bltu", 1'b0, 32'h204, 1'b1, 1'b0);
    @(negedge clk);
    check_bit("bltu.drained", out_valid, 1'b0);

    $display("[TB] four entries against a stalled consumer");
    out_ready = 1'b0;
    apply_stimulus(32'd1, 32'd2, F3_BNE, 32'h1000, 32'h10, 1'b1);
    @(negedge clk);
    apply_stimulus(32'd3, 32'd7, F3_BGE, 32'h2000, 32'h8, 1'b0);
    #1 check_bit("stall.in_ready1", in_ready, 1'b1);
    @(negedge clk);
    apply_stimulus(32'h8000_0000, 32'd1, F3_BGEU, 32'h3000, 32'hFFFF_FFF0, 1'b0);
    #1 check_bit("stall.in_ready_low", in_ready, 1'b0);
    check_output("stall.e0", 1'b1, 32'h1010, 1'b0, 1'b0);
    repeat (2) begin
      @(negedge clk);
      check_bit("stall.in_ready_held", in_ready, 1'b0);
      check_output("stall.e0_hold", 1'b1, 32'h1010, 1'b0, 1'b0);
    end
    out_ready = 1'b1;
    #1 check_bit("stall.release", in_ready, 1'b1);
    @(negedge clk);
    check_output("stall.e1", 1'b0, 32'h2004, 1'b0, 1'b0);
    apply_stimulus(32'h8000_0000, 32'd0, F3_BLT, 32'h4000, 32'h100, 1'b1);
    @(negedge clk);
    go_idle();
    check_output("stall.e2", 1'b1, 32'h2FF0, 1'b1, 1'b0);
    @(negedge clk);
    check_output("stall.e3", 1'b1, 32'h4100, 1'b0, 1'b0);
    @(negedge clk);
    check_bit("stall.drained", out_valid, 1'b0);

    $display("[TB] flush of a full pipe");
    out_ready = 1'b0;
    apply_stimulus(32'd1, 32'd1, F3_BEQ, 32'h600, 32'h10, 1'b0);
    @(negedge clk);
    apply_stimulus(32'd2, 32'd3, F3_BNE, 32'h640, 32'h10, 1'b0);
    @(negedge clk);
    check_bit("flush.full", out_valid, 1'b1);
    flush = 1'b1;
    apply_stimulus(32'd9, 32'd9, F3_BEQ, 32'h680, 32'h10, 1'b0);
    @(negedge clk);
    flush = 1'b0;
    go_idle();
    check_bit("flush.out_valid", out_valid, 1'b0);
    check_bit("flush.in_ready", in_ready, 1'b1);
    out_ready = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check_bit("flush.no_stale", out_valid, 1'b0);
    end
    apply_stimulus(32'h1234, 32'h1234, F3_BEQ, 32'hFFFF_FFF0, 32'h20, 1'b1);
    @(negedge clk);
    go_idle();
    @(negedge clk);
    check_output("wrap", 1'b1, 32'h0000_0010, 1'b0, 1'b0);
    @(negedge clk);
    check_bit("wrap.drained", out_valid, 1'b0);
`ifdef BRANCH_RESOLVE_STATS_EN
    check_word("stats.branches", stat_branches, 32'd8);
`endif

    $display("[TB] illegal funct3");
    apply_stimulus(32'h77, 32'h77, 3'b010, 32'h500, 32'h40, 1'b1);
    @(negedge clk);
    go_idle();
    @(negedge clk);
    check_output("illegal", 1'b0, 32'h504, 1'b1, 1'b1);
    @(negedge clk);
    check_bit("illegal.drained", out_valid, 1'b0);
`ifdef BRANCH_RESOLVE_STATS_EN
    check_word("stats.branches_after_illegal", stat_branches, 32'd8);
    check_word("stats.taken", stat_taken, 32'd6);
    check_word("stats.mispredict", stat_mispredict, 32'd4);
`endif

    $display("[TB] reset during stall");
    out_ready = 1'b0;
    apply_stimulus(32'd1, 32'd2, F3_BNE, 32'h700, 32'h8, 1'b0);
    @(negedge clk);
    go_idle();
    @(negedge clk);
    check_bit("rst.before", out_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check_bit("rst.out_valid", out_valid, 1'b0);
    check_bit("rst.taken", taken, 1'b0);
    check_word("rst.next_pc", next_pc, 32'h0);
`ifdef BRANCH_RESOLVE_STATS_EN
    check_word("rst.stats", stat_branches, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check_bit("rst.after", out_valid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
